// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl
//   Sequencer for a PRBS31 LFSR engine. Seeds the generator, gates it into
//   num_bursts bursts of burst_len bits separated by gap_len idle cycles,
//   and pulses done on normal completion. abort returns to IDLE at once.
//
//   Optional feature macro: PRBS_CHECK_EN
//     Defined   - gen_bit/tx_valid are delayed LOOP_LAT cycles and compared
//                 against rx_bit; mismatches accumulate in err_cnt
//                 (saturating). The delay line keeps draining after the run.
//     Undefined - no delay line, err_cnt is 0, rx_bit is unused.
//
// Ports
//   clk         clock
//   rst_n       synchronous reset, active-high (1 = reset)
//   start       start pulse, accepted only in IDLE
//   abort       stop immediately, any state; wins over start
//   seed_in     LFSR seed, sampled with start
//   burst_len   bits per burst, sampled with start
//   gap_len     idle cycles between bursts, sampled with start
//   num_bursts  burst count, sampled with start
//   gen_bit     current generator output bit
//   rx_bit      loopback receive bit
//   gen_load    one-cycle LFSR load strobe
//   gen_seed    seed presented with gen_load (never zero)
//   gen_en      LFSR advance enable
//   tx_valid    gen_bit is a transmitted bit this cycle (same as gen_en)
//   busy        high in every state except IDLE
//   done        one-cycle pulse on normal completion
//   err_cnt     saturating mismatch count

module prbs_burst_ctrl #(
  parameter int LOOP_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [30:0]      seed_in,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [7:0]       gap_len,
  input  logic [7:0]       num_bursts,
  input  logic             gen_bit,
  input  logic             rx_bit,
  output logic             gen_load,
  output logic [30:0]      gen_seed,
  output logic             gen_en,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] burst_len_q;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_len_q;
  logic [7:0]       num_bursts_q;
  logic [7:0]       burst_cnt;
  logic [7:0]       gap_cnt;

  assign tx_valid = gen_en;

  // Outputs are registered together with the state they belong to, so each
  // transition also loads the output values of the destination state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      gen_load <= 1'b0;
      gen_seed <= '0;
      gen_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= IDLE;
      gen_load <= 1'b0;
      gen_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            burst_len_q  <= burst_len;
            gap_len_q    <= gap_len;
            num_bursts_q <= num_bursts;
            // All-zero is the LFSR lockup state; substitute 1.
            gen_seed     <= (seed_in == 31'd0) ? 31'd1 : seed_in;
            gen_load     <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end

        LOAD: begin
          gen_load  <= 1'b0;
          bit_cnt   <= burst_len_q;
          burst_cnt <= num_bursts_q;
          if (burst_len_q == '0 || num_bursts_q == 8'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            gen_en <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          if (bit_cnt == CNT_W'(1)) begin
            burst_cnt <= burst_cnt - 8'd1;
            if (burst_cnt == 8'd1) begin
              gen_en <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (gap_len_q == 8'd0) begin
              // Back-to-back bursts: gen_en stays high, no dead cycle.
              bit_cnt <= burst_len_q;
            end else begin
              gen_en  <= 1'b0;
              gap_cnt <= gap_len_q;
              state   <= GAP;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == 8'd1) begin
            bit_cnt <= burst_len_q;
            gen_en  <= 1'b1;
            state   <= RUN;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          gen_load <= 1'b0;
          gen_en   <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef PRBS_CHECK_EN
  logic [LOOP_LAT-1:0] bit_p;
  logic [LOOP_LAT-1:0] vld_p;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage boundary: transmitted bit enters the LOOP_LAT-deep delay line;
  // the last stage lines up with the returned rx_bit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bit_p   <= '0;
      vld_p   <= '0;
      err_cnt <= '0;
    end else if (abort) begin
      bit_p <= '0;
      vld_p <= '0;
    end else begin
      for (int i = LOOP_LAT - 1; i > 0; i--) begin
        bit_p[i] <= bit_p[i-1];
        vld_p[i] <= vld_p[i-1];
      end
      bit_p[0] <= gen_bit;
      vld_p[0] <= gen_en;
      if (state == LOAD) begin
        err_cnt <= '0;
      end else if (vld_p[LOOP_LAT-1] && (rx_bit != bit_p[LOOP_LAT-1])) begin
        err_cnt <= sat_inc(err_cnt);
      end
    end
  end
`else
  logic unused_in;
  assign unused_in = ^{rx_bit, gen_bit, 32'(LOOP_LAT)};
  assign err_cnt   = '0;
`endif

endmodule
